// File: rtl/buffer_escrita_registradores.sv
// buffer_escrita_registradores
// Write-back buffer between the execute stage and the register bank write
// port. Results (destination, value) are accepted through a valid/ready
// handshake, queued in a small FIFO and drained one per clock into a
// registered write stage that drives the bank. Values not yet committed to
// the bank are forwarded to the two read ports.
//
// Handshake: a result is taken at a rising edge when entrada_valida and
// entrada_pronta are both high. entrada_pronta depends only on the current
// occupancy, never on a pop in the same cycle. Results for register 0 are
// taken and dropped.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   entrada_valida/entrada_pronta producer handshake
//   endereco_in, dado_in         incoming destination register and value
//   banco_ocupado                bank write port busy, stalls the drain
//   escrita_en, endereco_regd, data_in  registered bank write port
//   endereco_reg1/2              read port addresses to forward for
//   fwd_valido1/2, fwd_valor1/2  forwarding hit and youngest pending value
//   vazio, cheio, ocupacao       FIFO status
module buffer_escrita_registradores #(
   parameter int PROFUNDIDADE = 4,
   parameter int LARGURA_DADO = 32,
   parameter int LARGURA_END  = 5
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            entrada_valida,
   output logic                            entrada_pronta,
   input  logic [LARGURA_END-1:0]          endereco_in,
   input  logic [LARGURA_DADO-1:0]         dado_in,
   input  logic                            banco_ocupado,
   output logic                            escrita_en,
   output logic [LARGURA_END-1:0]          endereco_regd,
   output logic [LARGURA_DADO-1:0]         data_in,
   input  logic [LARGURA_END-1:0]          endereco_reg1,
   input  logic [LARGURA_END-1:0]          endereco_reg2,
   output logic                            fwd_valido1,
   output logic [LARGURA_DADO-1:0]         fwd_valor1,
   output logic                            fwd_valido2,
   output logic [LARGURA_DADO-1:0]         fwd_valor2,
   output logic                            vazio,
   output logic                            cheio,
   output logic [$clog2(PROFUNDIDADE):0]   ocupacao
);

   localparam int PW = $clog2(PROFUNDIDADE);

   logic [LARGURA_END-1:0]  mem_end_q  [PROFUNDIDADE];
   logic [LARGURA_DADO-1:0] mem_dado_q [PROFUNDIDADE];

   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW:0]             ocup_q, ocup_d;
   logic                    esc_en_q, esc_en_d;
   logic [LARGURA_END-1:0]  end_q, end_d;
   logic [LARGURA_DADO-1:0] dado_q, dado_d;

   logic push, pop;

   assign vazio          = (ocup_q == '0);
   assign cheio          = (ocup_q == (PW+1)'(PROFUNDIDADE));
   assign entrada_pronta = !cheio;
   assign ocupacao       = ocup_q;
   assign escrita_en     = esc_en_q;
   assign endereco_regd  = end_q;
   assign data_in        = dado_q;

   // Register 0 results complete the handshake but never occupy a slot.
   assign push = entrada_valida && entrada_pronta && (endereco_in != '0);
   assign pop  = !vazio && !banco_ocupado;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ocup_d   = ocup_q;
      esc_en_d = 1'b0;
      end_d    = end_q;
      dado_d   = dado_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         esc_en_d = 1'b1;
         end_d    = mem_end_q[rd_ptr_q];
         dado_d   = mem_dado_q[rd_ptr_q];
      end

      case ({push, pop})
         2'b10:   ocup_d = ocup_q + 1'b1;
         2'b01:   ocup_d = ocup_q - 1'b1;
         default: ocup_d = ocup_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ocup_q   <= '0;
         esc_en_q <= 1'b0;
         end_q    <= '0;
         dado_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ocup_q   <= ocup_d;
         esc_en_q <= esc_en_d;
         end_q    <= end_d;
         dado_q   <= dado_d;
      end
   end

   // Storage needs no reset: the pointers and occupancy define what is live.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_end_q[wr_ptr_q]  <= endereco_in;
         mem_dado_q[wr_ptr_q] <= dado_in;
      end
   end

   // Forwarding search. The write stage is checked first and live FIFO
   // entries are then walked oldest to youngest, so a later match overrides
   // an earlier one and the youngest pending value wins. Returns {hit, value}.
   function automatic logic [LARGURA_DADO:0] busca(input logic [LARGURA_END-1:0] a);
      logic [LARGURA_DADO:0] r;
      logic [PW-1:0]         idx;
      r = '0;
      if (a != '0) begin
         if (esc_en_q && (end_q == a)) begin
            r = {1'b1, dado_q};
         end
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < ocup_q) && (mem_end_q[idx] == a)) begin
               r = {1'b1, mem_dado_q[idx]};
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      {fwd_valido1, fwd_valor1} = busca(endereco_reg1);
      {fwd_valido2, fwd_valor2} = busca(endereco_reg2);
   end

endmodule
